// File: rtl/external_link_arbiter_if.sv
// Handshake bundle between the per-link FIFOs and the shared tagged inter-FPGA channel.
// The slave modport is the arbiter's side; master is the link/channel environment.
interface external_link_arbiter_if #(
  parameter int NUM_LINKS      = 4,
  parameter int FIFO_DATA_SIZE = 10,
  parameter int TAG_WIDTH      = $clog2(NUM_LINKS)
) ();
  localparam int CH_W = TAG_WIDTH + FIFO_DATA_SIZE;

  logic [NUM_LINKS*FIFO_DATA_SIZE-1:0] link_out_data;
  logic [NUM_LINKS-1:0]                link_out_valid;
  logic [NUM_LINKS-1:0]                link_out_ready;
  logic [CH_W-1:0]                     ch_out_data;
  logic                                ch_out_valid;
  logic                                ch_out_ready;
  logic [CH_W-1:0]                     ch_in_data;
  logic                                ch_in_valid;
  logic                                ch_in_ready;
  logic [NUM_LINKS*FIFO_DATA_SIZE-1:0] link_in_data;
  logic [NUM_LINKS-1:0]                link_in_valid;
  logic [NUM_LINKS-1:0]                link_in_ready;

  modport slave (
    input  link_out_data, link_out_valid, ch_out_ready, ch_in_data, ch_in_valid, link_in_ready,
    output link_out_ready, ch_out_data, ch_out_valid, ch_in_ready, link_in_data, link_in_valid
  );

  modport master (
    output link_out_data, link_out_valid, ch_out_ready, ch_in_data, ch_in_valid, link_in_ready,
    input  link_out_ready, ch_out_data, ch_out_valid, ch_in_ready, link_in_data, link_in_valid
  );
endinterface

// File: rtl/external_link_arbiter.sv
// Multiplexes NUM_LINKS neighbor links onto one tagged channel (round-robin, 1-beat obuf)
// and demultiplexes the inbound tagged channel back to the links through a 1-beat ibuf.
module external_link_lane #(
  parameter int LANE      = 0,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 ibuf_vld,
  input  logic [TAG_WIDTH-1:0] ibuf_tag,
  input  logic                 grant,
  input  logic [TAG_WIDTH-1:0] win_idx,
  input  logic                 link_in_ready,
  output logic                 link_in_valid,
  output logic                 drain,
  output logic                 link_out_ready
);
  localparam logic [TAG_WIDTH-1:0] ID = TAG_WIDTH'(LANE);

  assign link_in_valid  = ibuf_vld && (ibuf_tag == ID);
  assign drain          = link_in_valid && link_in_ready;
  assign link_out_ready = grant && (win_idx == ID);
endmodule

module external_link_arbiter #(
  parameter int                     NUM_LINKS                 = 4,
  parameter int                     FIFO_DATA_SIZE            = 10,
  parameter int                     TAG_WIDTH                 = $clog2(NUM_LINKS),
  parameter int                     STAGE_WIDTH               = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(2)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] global_stage,
  external_link_arbiter_if.slave bus,
  output logic                   idle,
  output logic                   err_bad_tag
);
  localparam int CH_W = TAG_WIDTH + FIFO_DATA_SIZE;
  localparam int TW1  = TAG_WIDTH + 1;
  // Link count in TAG_WIDTH+1 bits so it never truncates when NUM_LINKS is a power of two.
  localparam logic [TW1-1:0]       NL   = TW1'(NUM_LINKS);
  localparam logic [TAG_WIDTH-1:0] LAST = TAG_WIDTH'(NUM_LINKS - 1);

  logic [NUM_LINKS-1:0][FIFO_DATA_SIZE-1:0] lod;
  logic [2*NUM_LINKS-1:0]  vv;
  logic [TW1-1:0]          win_off, win_sum;
  logic [TAG_WIDTH-1:0]    win_idx, rr_ptr;
  logic [FIFO_DATA_SIZE-1:0] win_data;
  logic                    win_found, flush, ob_accept, grant;
  logic                    obuf_vld, ibuf_vld, drain, accept, good_tag;
  logic [CH_W-1:0]         obuf_data;
  logic [TAG_WIDTH-1:0]    ibuf_tag, in_tag;
  logic [FIFO_DATA_SIZE-1:0] ibuf_data;
  logic [NUM_LINKS-1:0]    drain_vec;

  assign lod   = bus.link_out_data;
  assign flush = (global_stage == STAGE_MEASUREMENT_LOADING);

  // Rotate valids so bit 0 is rr_ptr; lowest set bit is the winner's offset.
  always_comb begin
    vv        = {bus.link_out_valid, bus.link_out_valid} >> rr_ptr;
    win_found = 1'b0;
    win_off   = '0;
    for (int k = NUM_LINKS - 1; k >= 0; k--) begin
      if (vv[k]) begin
        win_found = 1'b1;
        win_off   = TW1'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + win_off;
    if (win_sum >= NL) win_sum = win_sum - NL;
    win_idx  = win_sum[TAG_WIDTH-1:0];
    win_data = '0;
    for (int i = 0; i < NUM_LINKS; i++) begin
      if (win_idx == TAG_WIDTH'(i)) win_data = lod[i];
    end
  end

  assign ob_accept = !obuf_vld || bus.ch_out_ready;
  // Gated by reset so no grant is offered while the block is held in reset.
  assign grant     = win_found && ob_accept && !flush && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obuf_vld  <= 1'b0;
      obuf_data <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      obuf_vld <= 1'b0;
      rr_ptr   <= '0;
    end else if (grant) begin
      obuf_vld  <= 1'b1;
      obuf_data <= {win_idx, win_data};
      rr_ptr    <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
    end else if (bus.ch_out_ready) begin
      obuf_vld <= 1'b0;
    end
  end

  assign bus.ch_out_valid = obuf_vld;
  assign bus.ch_out_data  = obuf_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINKS; gi++) begin : g_lane
      external_link_lane #(.LANE(gi), .TAG_WIDTH(TAG_WIDTH)) u_lane (
        .ibuf_vld       (ibuf_vld),
        .ibuf_tag       (ibuf_tag),
        .grant          (grant),
        .win_idx        (win_idx),
        .link_in_ready  (bus.link_in_ready[gi]),
        .link_in_valid  (bus.link_in_valid[gi]),
        .drain          (drain_vec[gi]),
        .link_out_ready (bus.link_out_ready[gi])
      );
    end
  endgenerate

  assign drain           = |drain_vec;
  assign bus.ch_in_ready = flush || !ibuf_vld || drain;
  assign in_tag          = bus.ch_in_data[CH_W-1 -: TAG_WIDTH];
  assign good_tag        = ({1'b0, in_tag} < NL);
  assign accept          = bus.ch_in_valid && bus.ch_in_ready && !flush;

  // A bad-tag beat is consumed but never loaded, so the ibuf simply empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ibuf_vld    <= 1'b0;
      ibuf_tag    <= '0;
      ibuf_data   <= '0;
      err_bad_tag <= 1'b0;
    end else begin
      if (accept && !good_tag) err_bad_tag <= 1'b1;
      if (flush) begin
        ibuf_vld <= 1'b0;
      end else if (accept && good_tag) begin
        ibuf_vld  <= 1'b1;
        ibuf_tag  <= in_tag;
        ibuf_data <= bus.ch_in_data[FIFO_DATA_SIZE-1:0];
      end else if (drain) begin
        ibuf_vld <= 1'b0;
      end
    end
  end

  assign bus.link_in_data = {NUM_LINKS{ibuf_data}};
  assign idle             = !obuf_vld && !ibuf_vld && (bus.link_out_valid == '0);
endmodule

// File: tb/tb_external_link_arbiter.sv
// Directed bench: table-driven round-robin/backpressure rows plus inbound, bad-tag,
// flush and asynchronous reset sequences.
module tb_external_link_arbiter;
  localparam int NL  = 4;
  localparam int FDS = 10;
  localparam int TW  = 3;
  localparam int SW  = 3;
  localparam logic [SW-1:0] ST_FLUSH = 3'd2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] global_stage = '0;
  logic          idle, err_bad_tag;

  external_link_arbiter_if #(.NUM_LINKS(NL), .FIFO_DATA_SIZE(FDS), .TAG_WIDTH(TW)) bus ();

  external_link_arbiter #(
    .NUM_LINKS(NL), .FIFO_DATA_SIZE(FDS), .TAG_WIDTH(TW),
    .STAGE_WIDTH(SW), .STAGE_MEASUREMENT_LOADING(ST_FLUSH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .global_stage (global_stage),
    .bus          (bus.slave),
    .idle         (idle),
    .err_bad_tag  (err_bad_tag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FDS-1:0] ldata(input int i);
    return FDS'(32'h3A0 + i);
  endfunction

  typedef struct {
    logic [NL-1:0] lov;
    logic          cor;
    logic [NL-1:0] lor;
    logic          cov;
    logic [TW-1:0] tag;
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{4'b1101, 1'b1, 4'b0001, 1'b1, 3'd0};
    tbl[1]  = '{4'b1101, 1'b1, 4'b0100, 1'b1, 3'd2};
    tbl[2]  = '{4'b1101, 1'b1, 4'b1000, 1'b1, 3'd3};
    tbl[3]  = '{4'b1101, 1'b1, 4'b0001, 1'b1, 3'd0};
    tbl[4]  = '{4'b1101, 1'b1, 4'b0100, 1'b1, 3'd2};
    tbl[5]  = '{4'b1101, 1'b1, 4'b1000, 1'b1, 3'd3};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[7]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 3'd1};
    tbl[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 3'd1};
    tbl[9]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 3'd1};
    tbl[10] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 3'd1};
    tbl[11] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 3'd1};
    tbl[12] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 3'd1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0};
    tbl[14] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 3'd2};
    tbl[15] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3'd3};
    tbl[16] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'd0};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0};

    for (int i = 0; i < NL; i++) bus.link_out_data[i*FDS +: FDS] = ldata(i);
    bus.link_out_valid = 4'b1111;
    bus.ch_out_ready   = 1'b0;
    bus.ch_in_data     = '0;
    bus.ch_in_valid    = 1'b0;
    bus.link_in_ready  = '0;

    // Reset state: grants suppressed even with links valid
    #2;
    check("rst lor", bus.link_out_ready, 4'b0000);
    check("rst cov", bus.ch_out_valid, 1'b0);
    check("rst liv", bus.link_in_valid, 4'b0000);
    check("rst cir", bus.ch_in_ready, 1'b1);
    check("rst err", err_bad_tag, 1'b0);
    check("rst idle busy", idle, 1'b0);
    bus.link_out_valid = '0;
    #1 check("rst idle", idle, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;

    // Outbound table: round-robin, backpressure hold, wrap
    for (int r = 0; r < 18; r++) begin
      bus.link_out_valid = tbl[r].lov;
      bus.ch_out_ready   = tbl[r].cor;
      #1 check($sformatf("row%0d lor", r), bus.link_out_ready, tbl[r].lor);
      @(posedge clk) #1;
      check($sformatf("row%0d cov", r), bus.ch_out_valid, tbl[r].cov);
      if (tbl[r].cov)
        check($sformatf("row%0d data", r), bus.ch_out_data, {tbl[r].tag, ldata(int'(tbl[r].tag))});
    end
    check("idle after table", idle, 1'b1);

    // Inbound tag 2 stalled 3 cycles, then replaced by tag 1 in the same cycle
    bus.ch_in_data  = {3'd2, 10'h155};
    bus.ch_in_valid = 1'b1;
    #1 check("in cir empty", bus.ch_in_ready, 1'b1);
    @(posedge clk) #1;
    bus.ch_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("in stall%0d liv", c), bus.link_in_valid, 4'b0100);
      check($sformatf("in stall%0d cir", c), bus.ch_in_ready, 1'b0);
      check($sformatf("in stall%0d data", c), bus.link_in_data[2*FDS +: FDS], 10'h155);
      @(posedge clk) #1;
    end
    bus.link_in_ready = 4'b0100;
    bus.ch_in_data    = {3'd1, 10'h0AA};
    bus.ch_in_valid   = 1'b1;
    #1 check("in drain liv", bus.link_in_valid, 4'b0100);
    check("in drain cir", bus.ch_in_ready, 1'b1);
    @(posedge clk) #1;
    bus.ch_in_valid = 1'b0;
    check("in replace liv", bus.link_in_valid, 4'b0010);
    check("in replace data", bus.link_in_data[1*FDS +: FDS], 10'h0AA);
    bus.link_in_ready = 4'b1111;
    @(posedge clk) #1;
    check("in empty liv", bus.link_in_valid, 4'b0000);

    // Bad tag 5 is swallowed and latches the sticky error
    bus.ch_in_data  = {3'd5, 10'h3FF};
    bus.ch_in_valid = 1'b1;
    #1 check("bad cir", bus.ch_in_ready, 1'b1);
    @(posedge clk) #1;
    bus.ch_in_valid = 1'b0;
    check("bad liv", bus.link_in_valid, 4'b0000);
    check("bad err", err_bad_tag, 1'b1);
    check("bad cir after", bus.ch_in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("bad err sticky", err_bad_tag, 1'b1);

    // Flush with obuf and ibuf full; rr_ptr was 1 beforehand
    bus.link_in_ready  = '0;
    bus.link_out_valid = 4'b0001;
    bus.ch_out_ready   = 1'b0;
    @(posedge clk) #1;
    bus.link_out_valid = '0;
    check("fl obuf full", bus.ch_out_valid, 1'b1);
    bus.ch_in_data  = {3'd3, 10'h077};
    bus.ch_in_valid = 1'b1;
    @(posedge clk) #1;
    bus.ch_in_valid = 1'b0;
    check("fl ibuf full", bus.link_in_valid, 4'b1000);
    global_stage       = ST_FLUSH;
    bus.link_out_valid = 4'b0010;
    bus.ch_in_data     = {3'd0, 10'h123};
    bus.ch_in_valid    = 1'b1;
    #1 check("fl lor", bus.link_out_ready, 4'b0000);
    check("fl cir", bus.ch_in_ready, 1'b1);
    @(posedge clk) #1;
    global_stage       = '0;
    bus.link_out_valid = '0;
    bus.ch_in_valid    = 1'b0;
    #1 check("fl cov", bus.ch_out_valid, 1'b0);
    check("fl liv", bus.link_in_valid, 4'b0000);
    check("fl idle", idle, 1'b1);
    check("fl err kept", err_bad_tag, 1'b1);
    bus.link_out_valid = 4'b1111;
    bus.ch_out_ready   = 1'b1;
    #1 check("fl rr0", bus.link_out_ready, 4'b0001);

    // Asynchronous reset mid-stream
    bus.ch_out_ready = 1'b0;
    @(posedge clk) #1;
    bus.ch_in_data  = {3'd0, 10'h011};
    bus.ch_in_valid = 1'b1;
    @(posedge clk) #1;
    bus.ch_in_valid = 1'b0;
    check("ar pre cov", bus.ch_out_valid, 1'b1);
    check("ar pre liv", bus.link_in_valid, 4'b0001);
    #2 reset = 1'b0;
    #1;
    check("ar cov", bus.ch_out_valid, 1'b0);
    check("ar liv", bus.link_in_valid, 4'b0000);
    check("ar lor", bus.link_out_ready, 4'b0000);
    check("ar cir", bus.ch_in_ready, 1'b1);
    check("ar err", err_bad_tag, 1'b0);
    check("ar cod", bus.ch_out_data, 13'h0);
    check("ar lid", bus.link_in_data, 40'h0);
    bus.link_out_valid = '0;
    #1 check("ar idle", idle, 1'b1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    check("ar post cov", bus.ch_out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
